// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Address width and special-register index are derived from DEPTH.
package reg_file_mp_pkg;

    localparam int W_DEF     = 16;
    localparam int DEPTH_DEF = 16;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int sp_idx_of(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/reg_file_mp_wr_arb.sv
// Resolves general and special write requests into per-register enable/data.
// Shared by the storage update and the read bypass path.
module rf_write_arb
    import reg_file_mp_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NW       = 2,
    parameter int ZERO_REG = 0,
    parameter int AW       = aw_of(DEPTH)
) (
    input  logic [NW-1:0]      we_i,
    input  logic [NW*AW-1:0]   waddr_i,
    input  logic [NW*W-1:0]    wdata_i,
    input  logic               sp_we_i,
    input  logic [W-1:0]       sp_wdata_i,
    output logic [DEPTH-1:0]   wen_o,
    output logic [DEPTH*W-1:0] wval_o
);

    localparam int SP = sp_idx_of(DEPTH);

    logic [AW-1:0] wa;

    // Special port first, then general ports in ascending order so the
    // highest enabled index overrides everything below it.
    always_comb begin
        wen_o  = '0;
        wval_o = '0;
        wa     = '0;
        if (sp_we_i) begin
            wen_o[SP]          = 1'b1;
            wval_o[SP*W +: W]  = sp_wdata_i;
        end
        for (int k = 0; k < NW; k++) begin
            if (we_i[k]) begin
                wa                       = waddr_i[k*AW +: AW];
                wen_o[wa]                = 1'b1;
                wval_o[int'(wa)*W +: W]  = wdata_i[k*W +: W];
            end
        end
        if (ZERO_REG != 0) begin
            wen_o[0]      = 1'b0;
            wval_o[W-1:0] = '0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with special-register port,
// busy scoreboard and a flattened full-state dump bus.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    parameter int AW       = aw_of(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   waddr,
    input  logic [NW*W-1:0]    wdata,
    input  logic               sp_we,
    input  logic [W-1:0]       sp_wdata,
    input  logic [NR*AW-1:0]   raddr,
    output logic [NR*W-1:0]    rdata,
    output logic [NR-1:0]      rbusy,
    output logic [W-1:0]       sp_rdata,
    input  logic               resv_v,
    input  logic [AW-1:0]      resv_addr,
    output logic [DEPTH*W-1:0] regs_all
);

    localparam int SP = sp_idx_of(DEPTH);

    logic [W-1:0]       regs_q [DEPTH];
    logic [DEPTH-1:0]   busy_q;
    logic [DEPTH-1:0]   busy_d;
    logic [DEPTH-1:0]   wen;
    logic [DEPTH*W-1:0] wval;
    logic [AW-1:0]      ra;

    rf_write_arb #(
        .W        (W),
        .DEPTH    (DEPTH),
        .NW       (NW),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_arb (
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .sp_we_i    (sp_we),
        .sp_wdata_i (sp_wdata),
        .wen_o      (wen),
        .wval_o     (wval)
    );

    // A reserve in the same cycle as a write marks the new producer: set wins.
    always_comb begin
        busy_d = busy_q & ~wen;
        if (resv_v && !(ZERO_REG != 0 && resv_addr == '0)) begin
            busy_d[resv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= wval[i*W +: W];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int r = 0; r < NR; r++) begin
            ra             = raddr[r*AW +: AW];
            rdata[r*W +: W] = regs_q[ra];
            rbusy[r]       = busy_q[ra];
            if (BYPASS != 0 && wen[ra]) begin
                rdata[r*W +: W] = wval[int'(ra)*W +: W];
                rbusy[r]        = 1'b0;
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rdata[r*W +: W] = '0;
                rbusy[r]        = 1'b0;
            end
        end
    end

    assign sp_rdata = regs_q[SP];

    for (genvar i = 0; i < DEPTH; i++) begin : g_dump
        assign regs_all[i*W +: W] = regs_q[i];
    end

endmodule
